// File: rtl/sa_feeder_if.sv
// Array-side streams of sa_feeder: operand beats towards the systolic array and
// result beats coming back from it. master = feeder, slave = array.
interface sa_feeder_if #(
    parameter int unsigned IN_WIDTH  = 4,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned SA_ROWS   = 2,
    parameter int unsigned SA_COLS   = 2
);
    logic                         io_sa_valid;
    logic                         io_sa_ready;
    logic [SA_ROWS*IN_WIDTH-1:0]  io_sa_a;
    logic [SA_COLS*IN_WIDTH-1:0]  io_sa_b;
    logic [SA_COLS*OUT_WIDTH-1:0] io_sa_c;
    logic                         io_res_valid;
    logic                         io_res_ready;
    logic [SA_COLS*OUT_WIDTH-1:0] io_res_c;

    modport master (
        output io_sa_valid, io_sa_a, io_sa_b, io_sa_c, io_res_ready,
        input  io_sa_ready, io_res_valid, io_res_c
    );

    modport slave (
        input  io_sa_valid, io_sa_a, io_sa_b, io_sa_c, io_res_ready,
        output io_sa_ready, io_res_valid, io_res_c
    );
endinterface

// File: rtl/sa_feeder.sv
// Operand sequencer and result collector for the systolic array: holds A and B, streams
// k-slices on start, collects result rows. Optional cycle counter: SA_FEEDER_PERF_EN.
module sa_feeder #(
    parameter int unsigned IN_WIDTH  = 4,
    parameter int unsigned OUT_WIDTH = 16,
    parameter int unsigned SA_ROWS   = 2,
    parameter int unsigned SA_COLS   = 2,
    localparam int unsigned MAX_DIM  = (SA_ROWS > SA_COLS) ? SA_ROWS : SA_COLS,
    localparam int unsigned LD_ROW_W = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1,
    localparam int unsigned RD_ROW_W = (SA_ROWS > 1) ? $clog2(SA_ROWS) : 1
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         io_ld_valid,
    output logic                         io_ld_ready,
    input  logic                         io_ld_sel,
    input  logic [LD_ROW_W-1:0]          io_ld_row,
    input  logic [SA_COLS*IN_WIDTH-1:0]  io_ld_data,
    input  logic                         io_start,
    output logic                         io_busy,
    output logic                         io_done,
    sa_feeder_if.master                  sa,
    input  logic [RD_ROW_W-1:0]          io_rd_row,
    output logic [SA_COLS*OUT_WIDTH-1:0] io_rd_data
`ifdef SA_FEEDER_PERF_EN
    ,
    output logic [31:0]                  io_perf_cycles
`endif
);
    localparam int unsigned K_W = (SA_COLS > 1) ? $clog2(SA_COLS) : 1;
    localparam int unsigned N_W = $clog2(SA_ROWS + 1);

    typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_e;

    state_e               state_q, state_d;
    logic [K_W-1:0]       k_q, k_d;
    logic [N_W-1:0]       n_q, n_d;
    logic [IN_WIDTH-1:0]  a_q [SA_ROWS][SA_COLS];
    logic [IN_WIDTH-1:0]  a_d [SA_ROWS][SA_COLS];
    logic [IN_WIDTH-1:0]  b_q [SA_COLS][SA_COLS];
    logic [IN_WIDTH-1:0]  b_d [SA_COLS][SA_COLS];
    logic [OUT_WIDTH-1:0] c_q [SA_ROWS][SA_COLS];
    logic [OUT_WIDTH-1:0] c_d [SA_ROWS][SA_COLS];

    logic                 ld_fire, sa_fire, res_fire, start_go, busy;
    logic [RD_ROW_W-1:0]  res_row;

    assign busy     = (state_q == StFeed) || (state_q == StDrain);
    assign ld_fire  = io_ld_valid && io_ld_ready;
    assign sa_fire  = sa.io_sa_valid && sa.io_sa_ready;
    assign res_fire = sa.io_res_valid && sa.io_res_ready;
    // The array emits result rows last-first.
    assign res_row  = RD_ROW_W'(SA_ROWS - 1 - 32'(n_q));

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        n_d      = n_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        start_go = 1'b0;

        if (res_fire) begin
            for (int j = 0; j < SA_COLS; j++) begin
                c_d[res_row][j] = sa.io_res_c[j*OUT_WIDTH +: OUT_WIDTH];
            end
            n_d = n_q + 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (ld_fire) begin
                    // Out-of-range rows are acknowledged but not written.
                    if (!io_ld_sel) begin
                        if (32'(io_ld_row) < SA_ROWS) begin
                            for (int j = 0; j < SA_COLS; j++) begin
                                a_d[RD_ROW_W'(io_ld_row)][j] = io_ld_data[j*IN_WIDTH +: IN_WIDTH];
                            end
                        end
                    end else if (32'(io_ld_row) < SA_COLS) begin
                        for (int j = 0; j < SA_COLS; j++) begin
                            b_d[K_W'(io_ld_row)][j] = io_ld_data[j*IN_WIDTH +: IN_WIDTH];
                        end
                    end
                end else if (io_start) begin
                    start_go = 1'b1;
                    state_d  = StFeed;
                    k_d      = '0;
                    n_d      = '0;
                    c_d      = '{default: '0};
                end
            end
            StFeed: begin
                if (sa_fire) begin
                    if (k_q == K_W'(SA_COLS - 1)) begin
                        state_d = StDrain;
                        k_d     = '0;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            StDrain: begin
                if (n_q == N_W'(SA_ROWS)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        io_ld_ready     = (state_q == StIdle) && !reset;
        io_busy         = busy;
        io_done         = (state_q == StDone);
        sa.io_sa_valid  = (state_q == StFeed);
        sa.io_res_ready = busy && (n_q < N_W'(SA_ROWS));
        sa.io_sa_c      = '0;
        sa.io_sa_a      = '0;
        sa.io_sa_b      = '0;
        io_rd_data      = '0;
        for (int r = 0; r < SA_ROWS; r++) begin
            sa.io_sa_a[r*IN_WIDTH +: IN_WIDTH] = a_q[r][k_q];
        end
        for (int j = 0; j < SA_COLS; j++) begin
            sa.io_sa_b[j*IN_WIDTH +: IN_WIDTH]    = b_q[k_q][j];
            io_rd_data[j*OUT_WIDTH +: OUT_WIDTH] = c_q[io_rd_row][j];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            k_q     <= '0;
            n_q     <= '0;
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            c_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            n_q     <= n_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
        end
    end

`ifdef SA_FEEDER_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (start_go) begin
            perf_d = '0;
        end else if (busy && (perf_q != '1)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign io_perf_cycles = perf_q;
`endif
endmodule

// File: tb/tb_sa_feeder.sv
// Self-checking bench for sa_feeder: table of matrix products plus hand-written
// backpressure, busy-start, busy-load and mid-feed reset sequences.
module tb_sa_feeder;
    localparam int unsigned IW = 4;
    localparam int unsigned OW = 16;
    localparam int unsigned R  = 2;
    localparam int unsigned C  = 2;

    typedef int mat_t [2][2];
    typedef struct {
        mat_t a;
        mat_t b;
        mat_t c;
    } vec_t;
    typedef struct {
        logic [R*IW-1:0] a;
        logic [C*IW-1:0] b;
    } beat_t;

    logic            clock = 1'b0;
    logic            reset;
    logic            io_ld_valid, io_ld_ready, io_ld_sel, io_start, io_busy, io_done;
    logic [0:0]      io_ld_row;
    logic [C*IW-1:0] io_ld_data;
    logic [0:0]      io_rd_row;
    logic [C*OW-1:0] io_rd_data;
`ifdef SA_FEEDER_PERF_EN
    logic [31:0]     io_perf_cycles;
`endif

    sa_feeder_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SA_ROWS(R), .SA_COLS(C)) sa_bus ();

    sa_feeder #(.IN_WIDTH(IW), .OUT_WIDTH(OW), .SA_ROWS(R), .SA_COLS(C)) dut (
        .clock       (clock),
        .reset       (reset),
        .io_ld_valid (io_ld_valid),
        .io_ld_ready (io_ld_ready),
        .io_ld_sel   (io_ld_sel),
        .io_ld_row   (io_ld_row),
        .io_ld_data  (io_ld_data),
        .io_start    (io_start),
        .io_busy     (io_busy),
        .io_done     (io_done),
        .sa          (sa_bus.master),
        .io_rd_row   (io_rd_row),
        .io_rd_data  (io_rd_data)
`ifdef SA_FEEDER_PERF_EN
        ,
        .io_perf_cycles (io_perf_cycles)
`endif
    );

    always #5 clock = ~clock;

    int     errors = 0;
    int     checks = 0;
    vec_t   vecs [5];
    mat_t   cur_a, cur_b, zero_m;
    beat_t  exp_q [$];
    logic [C*OW-1:0] res_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic load_row(input bit sel, input int row, input int d0, input int d1);
        @(negedge clock);
        io_ld_valid = 1'b1;
        io_ld_sel   = sel;
        io_ld_row   = 1'(row);
        io_ld_data  = {4'(d1), 4'(d0)};
        #1 check("ld_ready_idle", 64'(io_ld_ready), 64'd1);
        @(negedge clock);
        io_ld_valid = 1'b0;
    endtask

    task automatic load_mat(input mat_t a, input mat_t b);
        for (int r = 0; r < 2; r++) load_row(1'b0, r, a[r][0], a[r][1]);
        for (int r = 0; r < 2; r++) load_row(1'b1, r, b[r][0], b[r][1]);
        cur_a = a;
        cur_b = b;
    endtask

    task automatic check_c(input mat_t e, input string tag);
        for (int r = 0; r < 2; r++) begin
            io_rd_row = 1'(r);
            #1 check(tag, 64'(io_rd_data), 64'({16'(e[r][1]), 16'(e[r][0])}));
        end
    endtask

    // Acts as the array: checks each accepted beat against the scoreboard, accumulates
    // the product from the beats it saw, and returns result rows last-first.
    task automatic run_job(input int stall, input bit start_in_drain, input bit ld_in_feed,
                           output int busy_cycles);
        int    done_cnt = 0;
        int    beats = 0;
        int    stall_left = stall;
        bit    pulsed = 1'b0;
        bit    finished = 1'b0;
        beat_t prev, e;
        int    acc [2][2] = '{'{0, 0}, '{0, 0}};
        busy_cycles = 0;
        exp_q.delete();
        res_q.delete();
        @(negedge clock);
        io_start = 1'b1;
        io_sa_ready_set(1'b1);
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back('{a: {4'(cur_a[1][k]), 4'(cur_a[0][k])},
                              b: {4'(cur_b[k][1]), 4'(cur_b[k][0])}});
        end
        @(negedge clock);
        check("valid_after_start", {62'd0, sa_bus.io_sa_valid, io_busy}, 64'd3);
        for (int cyc = 0; cyc < 200; cyc++) begin
            io_start    = 1'b0;
            io_ld_valid = 1'b0;
            if (io_done) begin
                done_cnt++;
            end else if (done_cnt > 0) begin
                finished = 1'b1;
                break;
            end
            if (io_busy) busy_cycles++;
            if (res_q.size() > 0) begin
                sa_bus.io_res_valid = 1'b1;
                sa_bus.io_res_c     = res_q[0];
                if (sa_bus.io_res_ready) void'(res_q.pop_front());
            end else begin
                sa_bus.io_res_valid = 1'b0;
                sa_bus.io_res_c     = '0;
            end
            if (sa_bus.io_sa_valid) begin
                if (beats == 0 && stall_left > 0) begin
                    sa_bus.io_sa_ready = 1'b0;
                    if (stall_left < stall) begin
                        check("stall_hold_a", 64'(sa_bus.io_sa_a), 64'(prev.a));
                        check("stall_hold_b", 64'(sa_bus.io_sa_b), 64'(prev.b));
                    end
                    prev = '{a: sa_bus.io_sa_a, b: sa_bus.io_sa_b};
                    stall_left--;
                end else begin
                    sa_bus.io_sa_ready = 1'b1;
                end
                if (ld_in_feed) begin
                    io_ld_valid = 1'b1;
                    io_ld_sel   = 1'b0;
                    io_ld_row   = 1'b0;
                    io_ld_data  = 8'hFF;
                    #1 check("ld_ready_feed", 64'(io_ld_ready), 64'd0);
                end
                if (sa_bus.io_sa_ready) begin
                    if (exp_q.size() == 0) begin
                        check("extra_beat", 64'(beats), 64'd2);
                    end else begin
                        e = exp_q.pop_front();
                        check("beat_a", 64'(sa_bus.io_sa_a), 64'(e.a));
                        check("beat_b", 64'(sa_bus.io_sa_b), 64'(e.b));
                    end
                    check("sa_c_zero", 64'(sa_bus.io_sa_c), 64'd0);
                    for (int r = 0; r < 2; r++)
                        for (int j = 0; j < 2; j++)
                            acc[r][j] += int'(sa_bus.io_sa_a[r*IW +: IW]) *
                                         int'(sa_bus.io_sa_b[j*IW +: IW]);
                    beats++;
                    if (beats == 2) begin
                        for (int r = 1; r >= 0; r--)
                            res_q.push_back({16'(acc[r][1]), 16'(acc[r][0])});
                    end
                end
            end
            if (start_in_drain && io_busy && !sa_bus.io_sa_valid && !pulsed) begin
                io_start = 1'b1;
                pulsed   = 1'b1;
            end
            @(negedge clock);
        end
        sa_bus.io_res_valid = 1'b0;
        io_start    = 1'b0;
        io_ld_valid = 1'b0;
        check("job_finished", 64'(finished), 64'd1);
        check("done_pulses", 64'(done_cnt), 64'd1);
        check("beats_sent", 64'(beats), 64'd2);
        check("ld_ready_after_done", 64'(io_ld_ready), 64'd1);
        if (start_in_drain) check("start_pulsed", 64'(pulsed), 64'd1);
    endtask

    task automatic io_sa_ready_set(input logic v);
        sa_bus.io_sa_ready = v;
    endtask

    initial begin
        int bc, bc_ref, stalled_bc, no_done;
        vecs[0] = '{a: '{'{1, 2}, '{3, 4}},     b: '{'{1, 0}, '{0, 1}},
                    c: '{'{1, 2}, '{3, 4}}};
        vecs[1] = '{a: '{'{1, 2}, '{3, 4}},     b: '{'{5, 6}, '{7, 8}},
                    c: '{'{19, 22}, '{43, 50}}};
        vecs[2] = '{a: '{'{15, 15}, '{15, 15}}, b: '{'{15, 15}, '{15, 15}},
                    c: '{'{450, 450}, '{450, 450}}};
        vecs[3] = '{a: '{'{0, 0}, '{0, 0}},     b: '{'{9, 3}, '{2, 7}},
                    c: '{'{0, 0}, '{0, 0}}};
        vecs[4] = '{a: '{'{2, 0}, '{0, 3}},     b: '{'{4, 5}, '{6, 7}},
                    c: '{'{8, 10}, '{18, 21}}};
        zero_m = '{'{0, 0}, '{0, 0}};

        reset = 1'b1;
        io_ld_valid = 1'b0; io_ld_sel = 1'b0; io_ld_row = '0; io_ld_data = '0;
        io_start = 1'b0; io_rd_row = '0;
        sa_bus.io_sa_ready = 1'b1; sa_bus.io_res_valid = 1'b0; sa_bus.io_res_c = '0;
        repeat (2) @(negedge clock);
        check("reset_outputs", {59'd0, io_ld_ready, sa_bus.io_sa_valid, sa_bus.io_res_ready,
                                io_busy, io_done}, 64'd0);
        check_c(zero_m, "reset_c");
        reset = 1'b0;
        #1 check("ld_ready_post_reset", 64'(io_ld_ready), 64'd1);

        for (int i = 0; i < 5; i++) begin
            load_mat(vecs[i].a, vecs[i].b);
            run_job(0, 1'b0, 1'b0, bc);
            check_c(vecs[i].c, "table_c");
`ifdef SA_FEEDER_PERF_EN
            check("perf_cycles", 64'(io_perf_cycles), 64'(bc));
`endif
            if (i == 1) bc_ref = bc;
        end

        // Backpressure on beat 0 with B = [[5,6],[7,8]].
        load_mat(vecs[1].a, vecs[1].b);
        run_job(3, 1'b0, 1'b0, stalled_bc);
        check_c(vecs[1].c, "stall_c");
        check("stall_busy_extra", 64'(stalled_bc - bc_ref), 64'd3);
`ifdef SA_FEEDER_PERF_EN
        check("perf_stall", 64'(io_perf_cycles), 64'(bc_ref + 3));
`endif

        // Start pulse during DRAIN is ignored and does not clear C.
        run_job(0, 1'b1, 1'b0, bc);
        check_c(vecs[1].c, "busy_start_c");
        repeat (3) @(negedge clock);
        check("idle_after_busy_start", {62'd0, io_busy, io_done}, 64'd0);

        // Load attempt during FEED is refused; a rerun proves A/B untouched.
        run_job(0, 1'b0, 1'b1, bc);
        check_c(vecs[1].c, "busy_load_c");
        run_job(0, 1'b0, 1'b0, bc);
        check_c(vecs[1].c, "rerun_c");

        // Result beats offered while idle must not be captured.
        @(negedge clock);
        sa_bus.io_res_valid = 1'b1;
        sa_bus.io_res_c     = 32'hDEAD_BEEF;
        repeat (2) @(negedge clock);
        sa_bus.io_res_valid = 1'b0;
        check_c(vecs[1].c, "idle_res_c");

        // Reset after beat 0 of a feed.
        load_mat(vecs[2].a, vecs[2].b);
        @(negedge clock);
        io_start = 1'b1;
        sa_bus.io_sa_ready = 1'b1;
        @(negedge clock);
        io_start = 1'b0;
        check("rst_seq_beat0", {55'd0, sa_bus.io_sa_valid, sa_bus.io_sa_a}, {55'd0, 1'b1, 8'hFF});
        @(negedge clock);
        check("rst_seq_beat1", 64'(sa_bus.io_sa_valid), 64'd1);
        reset = 1'b1;
        @(negedge clock);
        check("mid_reset_outputs", {59'd0, io_ld_ready, sa_bus.io_sa_valid, sa_bus.io_res_ready,
                                    io_busy, io_done}, 64'd0);
        reset = 1'b0;
        check_c(zero_m, "mid_reset_c");
        no_done = 0;
        repeat (4) begin
            @(negedge clock);
            if (io_done || io_busy) no_done++;
        end
        check("no_done_after_reset", 64'(no_done), 64'd0);
        cur_a = zero_m;
        cur_b = zero_m;
        run_job(0, 1'b0, 1'b0, bc);
        check_c(zero_m, "zero_banks_c");
        load_mat(vecs[4].a, vecs[4].b);
        run_job(0, 1'b0, 1'b0, bc);
        check_c(vecs[4].c, "post_reset_c");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
